fft_128: RTL and testbench

// - Receive-side demodulator for one 128-sample real OFDM-style frame (Q1.15 time samples).
// - Computes the real part of 24 forward-DFT bins: k = 4, 6, ..., 50.
// - Slices each bin into a 2-bit amplitude code and emits one packed 48-bit word per frame.
// - Sits after the sample source; the payload consumer takes DataOut when PushOut pulses.

---
 rtl/fft_128.sv | 183 ++++++++++++++++++
 tb/tb_fft_128.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fft_128.sv
// fft_128: single-frame real-part DFT demodulator.
// Absorbs one 128-sample frame (Q1.15) and accumulates the real part of
// 24 DFT bins (k = 4, 6, ..., 50). Each bin is sliced into a 2-bit amplitude
// code, and the 48 code bits are emitted as one word per frame.
// Ports:
//   Clk       - rising-edge clock
//   Reset     - asynchronous, active-high reset
//   Pushin    - input sample valid
//   FirstData - marks the current Pushin sample as frame index 0
//   DinR/DinI - signed Q1.15 real/imaginary sample
//   PushOut   - one-cycle strobe, DataOut holds a new frame result
//   DataOut   - packed codes, bin 4+2m at DataOut[2m+1:2m]
module fft_128 (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Pushin,
  input  logic        FirstData,
  input  logic [16:0] DinR,
  input  logic [16:0] DinI,
  output logic        PushOut,
  output logic [47:0] DataOut
);

  localparam int unsigned NumBins = 24;

  typedef enum logic [1:0] {StIdle, StAcc, StDec} state_e;

  state_e             state_q, state_d;
  logic [6:0]         idx_q, idx_d;
  logic signed [39:0] acc_q [NumBins];
  logic signed [39:0] acc_d [NumBins];
  logic signed [39:0] term  [NumBins];
  logic [47:0]        code_q, code_d;
  logic               code_vld_q, code_vld_d;
  logic [47:0]        data_out_q, data_out_d;
  logic               push_out_q, push_out_d;

  logic               start, absorb;
  logic [6:0]         n_cur;
  logic signed [16:0] din_r, din_i;

  assign din_r = DinR;
  assign din_i = DinI;

  // Quarter-wave cos table: round(32768*cos(2*pi*i/128)), i = 0..32.
  function automatic logic signed [16:0] cos_rom(input logic [5:0] i);
    case (i)
      6'd0:  cos_rom = 17'sd32767;  6'd1:  cos_rom = 17'sd32729;
      6'd2:  cos_rom = 17'sd32610;  6'd3:  cos_rom = 17'sd32413;
      6'd4:  cos_rom = 17'sd32138;  6'd5:  cos_rom = 17'sd31786;
      6'd6:  cos_rom = 17'sd31357;  6'd7:  cos_rom = 17'sd30853;
      6'd8:  cos_rom = 17'sd30274;  6'd9:  cos_rom = 17'sd29622;
      6'd10: cos_rom = 17'sd28899;  6'd11: cos_rom = 17'sd28106;
      6'd12: cos_rom = 17'sd27246;  6'd13: cos_rom = 17'sd26320;
      6'd14: cos_rom = 17'sd25330;  6'd15: cos_rom = 17'sd24279;
      6'd16: cos_rom = 17'sd23170;  6'd17: cos_rom = 17'sd22006;
      6'd18: cos_rom = 17'sd20788;  6'd19: cos_rom = 17'sd19520;
      6'd20: cos_rom = 17'sd18205;  6'd21: cos_rom = 17'sd16846;
      6'd22: cos_rom = 17'sd15447;  6'd23: cos_rom = 17'sd14010;
      6'd24: cos_rom = 17'sd12540;  6'd25: cos_rom = 17'sd11039;
      6'd26: cos_rom = 17'sd9512;   6'd27: cos_rom = 17'sd7962;
      6'd28: cos_rom = 17'sd6393;   6'd29: cos_rom = 17'sd4808;
      6'd30: cos_rom = 17'sd3212;   6'd31: cos_rom = 17'sd1608;
      default: cos_rom = 17'sd0;
    endcase
  endfunction

  // Full-circle cos from the quarter table by quadrant folding.
  function automatic logic signed [16:0] cos_full(input logic [6:0] p);
    logic [6:0] q;
    if (p <= 7'd32) begin
      q = p;
      cos_full = cos_rom(q[5:0]);
    end else if (p <= 7'd64) begin
      q = 7'd64 - p;
      cos_full = -cos_rom(q[5:0]);
    end else if (p <= 7'd96) begin
      q = p - 7'd64;
      cos_full = -cos_rom(q[5:0]);
    end else begin
      q = 7'd0 - p;
      cos_full = cos_rom(q[5:0]);
    end
  endfunction

  // Negative values fall below the first threshold and slice to 0.
  function automatic logic [1:0] slice(input logic signed [39:0] a);
    if (a < 40'sd5461)       slice = 2'd0;
    else if (a < 40'sd16384) slice = 2'd1;
    else if (a < 40'sd27307) slice = 2'd2;
    else                     slice = 2'd3;
  endfunction

  assign start  = Pushin && FirstData;
  assign absorb = start || (Pushin && (state_q == StAcc));
  assign n_cur  = start ? 7'd0 : idx_q;

  for (genvar m = 0; m < NumBins; m++) begin : g_bin
    logic [13:0]        kn;
    logic [6:0]         p_cos, p_sin;
    logic signed [16:0] c, s;
    logic signed [33:0] pr, pi;
    logic signed [34:0] sum;
    logic signed [39:0] sum_ext;

    always_comb begin
      kn      = 14'(4 + 2 * m) * {7'd0, n_cur};
      p_cos   = kn[6:0];
      p_sin   = p_cos - 7'd32;  // sin(theta) = cos(theta - pi/2), wraps mod 128
      c       = cos_full(p_cos);
      s       = cos_full(p_sin);
      pr      = din_r * c;
      pi      = din_i * s;
      sum     = 35'(pr) + 35'(pi);
      sum_ext = 40'(sum);
    end

    assign term[m] = sum_ext >>> 15;
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    code_d     = code_q;
    code_vld_d = 1'b0;
    data_out_d = data_out_q;
    push_out_d = 1'b0;
    for (int m = 0; m < NumBins; m++) begin
      acc_d[m] = acc_q[m];
    end

    // Second result stage: present the sliced word one cycle after DEC.
    if (code_vld_q) begin
      data_out_d = code_q;
      push_out_d = 1'b1;
    end

    // DEC slices the finished accumulators even if a new frame starts now.
    if (state_q == StDec) begin
      for (int m = 0; m < NumBins; m++) begin
        code_d[2*m +: 2] = slice(acc_q[m]);
      end
      code_vld_d = 1'b1;
      state_d    = StIdle;
    end

    if (absorb) begin
      for (int m = 0; m < NumBins; m++) begin
        acc_d[m] = (n_cur == 7'd0) ? term[m] : acc_q[m] + term[m];
      end
      idx_d   = n_cur + 7'd1;
      state_d = (n_cur == 7'd127) ? StDec : StAcc;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      code_q     <= '0;
      code_vld_q <= 1'b0;
      data_out_q <= '0;
      push_out_q <= 1'b0;
      for (int m = 0; m < NumBins; m++) begin
        acc_q[m] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      code_q     <= code_d;
      code_vld_q <= code_vld_d;
      data_out_q <= data_out_d;
      push_out_q <= push_out_d;
      for (int m = 0; m < NumBins; m++) begin
        acc_q[m] <= acc_d[m];
      end
    end
  end

  assign PushOut = push_out_q;
  assign DataOut = data_out_q;

endmodule

// File: tb/tb_fft_128.sv
// Testbench for fft_128: synthesizes real frames by inverse DFT of a payload,
// drives them, and scoreboards the expected words and output latency.
module tb_fft_128;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Pushin;
  logic        FirstData;
  logic [16:0] DinR;
  logic [16:0] DinI;
  logic        PushOut;
  logic [47:0] DataOut;

  fft_128 dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Pushin    (Pushin),
    .FirstData (FirstData),
    .DinR      (DinR),
    .DinI      (DinI),
    .PushOut   (PushOut),
    .DataOut   (DataOut)
  );

  always #5 Clk = ~Clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          samp [128];
  logic [47:0] exp_q [$];
  int          edge_q [$];

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // x[n] = 32768/128 * sum over bins of amp * 2cos(2*pi*k*n/128), plus pilot 55.
  task automatic build(input logic [47:0] payload);
    real pi2, acc, amp, x;
    pi2 = 2.0 * 3.14159265358979;
    for (int n = 0; n < 128; n++) begin
      acc = 2.0 * $cos(pi2 * 55.0 * n / 128.0);
      for (int m = 0; m < 24; m++) begin
        amp = payload[2*m +: 2] / 3.0;
        acc = acc + 2.0 * amp * $cos(pi2 * (4.0 + 2.0 * m) * n / 128.0);
      end
      x = acc * 256.0;
      samp[n] = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(negedge Clk);
      Pushin    = 1'b0;
      FirstData = 1'b0;
    end
  endtask

  // Drives samples 0..stop_at-1; a complete frame registers its expected word.
  task automatic send_frame(input logic [47:0] payload, input int gap_every,
                            input int stop_at);
    build(payload);
    for (int n = 0; n < 128; n++) begin
      if (n == stop_at) break;
      if (gap_every > 0 && n > 0 && (n % gap_every) == 0) idle(1);
      @(negedge Clk);
      Pushin    = 1'b1;
      FirstData = (n == 0);
      DinR      = samp[n][16:0];
      DinI      = '0;
      if (n == 127) begin
        exp_q.push_back(payload);
        edge_q.push_back(cyc + 1);
      end
    end
  endtask

  always @(negedge Clk) begin
    if (!Reset && PushOut) begin
      check_eq("pushout_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        check_eq("dataout", 64'(DataOut), 64'(exp_q.pop_front()));
        check_eq("latency", 64'(cyc - edge_q.pop_front()), 64'd2);
      end
    end
  end

  initial begin
    Reset     = 1'b1;
    Pushin    = 1'b0;
    FirstData = 1'b0;
    DinR      = '0;
    DinI      = '0;
    repeat (3) @(negedge Clk);
    check_eq("reset_dataout", 64'(DataOut), 64'd0);
    check_eq("reset_pushout", 64'(PushOut), 64'd0);
    Reset = 1'b0;
    idle(2);

    send_frame(48'hE23456789F1B, 0, 128);
    idle(5);

    send_frame(48'hE23456789F1B, 0, 128);
    send_frame(48'hE23456789F1B, 0, 128);
    idle(5);

    send_frame(48'hA5A5A5A5A5A5, 0, 128);
    send_frame(48'h000000000000, 0, 128);
    idle(5);

    send_frame(48'hFFFFFFFFFFFF, 8, 128);
    idle(5);

    // Reset mid-frame: partial frame must vanish, outputs cleared.
    send_frame(48'h555555555555, 0, 60);
    @(negedge Clk);
    Pushin = 1'b0;
    FirstData = 1'b0;
    Reset  = 1'b1;
    @(negedge Clk);
    check_eq("midreset_dataout", 64'(DataOut), 64'd0);
    check_eq("midreset_pushout", 64'(PushOut), 64'd0);
    Reset = 1'b0;
    idle(3);
    check_eq("postreset_dataout", 64'(DataOut), 64'd0);
    send_frame(48'h555555555555, 0, 128);
    idle(5);

    // Frame abandoned by FirstData at sample 90.
    send_frame(48'h123456789ABC, 0, 90);
    send_frame(48'h100000000001, 0, 128);
    idle(6);

    check_eq("all_frames_out", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
